// File: rtl/sram_controller.sv
// Bridges a 32-bit MEM-stage load/store to a 16-bit asynchronous SRAM,
// moving low then high halfword, then idling the bus for WAIT_CYCLES before completing.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOW  = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  cnt;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] wdata;
  logic [15:0] rd_low;
  logic [16:0] word_next;

  // Addresses below BASE_ADDR wrap modulo the 17-bit word space.
  assign word_next = 17'((address - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      read_data <= '0;
      op_wr     <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      rd_low    <= '0;
    end else begin
      case (state)
        S_IDLE: if (wr_en || rd_en) begin
          op_wr <= wr_en;
          word  <= word_next;
          wdata <= write_data;
          state <= S_LOW;
        end
        S_LOW: begin
          if (!op_wr) rd_low <= sram_dq_in;
          state <= S_HIGH;
        end
        S_HIGH: begin
          if (!op_wr) read_data <= {sram_dq_in, rd_low};
          cnt   <= WAIT_LAST;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 3'd0) state <= S_DONE;
          else             cnt   <= cnt - 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready = ((state == S_IDLE) && !(wr_en || rd_en)) || (state == S_DONE);

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if ((state == S_LOW) || (state == S_HIGH)) begin
      sram_addr = {word, state == S_HIGH};
      if (op_wr) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == S_HIGH) ? wdata[31:16] : wdata[15:0];
      end
    end
  end

  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed + randomized bench for sram_controller: a transaction-level model
// with reference memory is compared against the DUT on every negedge.
module tb_sram_controller;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int W = 2;
  localparam int DONE_K = 3 + W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in = '0;
  logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM device on the bus and the model's reference memory, same power-up pattern
  logic [15:0] bus_mem[bit [17:0]];
  logic [15:0] ref_mem[bit [17:0]];

  function automatic logic [15:0] init_hw(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A ^ {a[17:16], 14'h0};
  endfunction
  function automatic logic [15:0] bus_rd(input logic [17:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_hw(a);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_hw(a);
  endfunction

  always @(posedge clk) if (!sram_we_n && sram_dq_oe) bus_mem[sram_addr] = sram_dq_out;
  always @(negedge clk) sram_dq_in = bus_rd(sram_addr);

  // Transaction model: k counts cycles into the access (1=low half, 2=high half, DONE_K=complete)
  bit          m_busy = 1'b0;
  int          m_k = 0;
  bit          m_wr = 1'b0;
  logic [16:0] m_w = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_rd = '0;

  always @(negedge clk) if (chk_en) begin
    logic        e_ready, e_we_n, e_oe;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    e_ready = 1'b0; e_we_n = 1'b1; e_oe = 1'b0; e_addr = '0; e_dq = '0;
    if (!m_busy) e_ready = !(wr_en || rd_en);
    else if (m_k == DONE_K) e_ready = 1'b1;
    if (m_busy && (m_k == 1 || m_k == 2)) begin
      e_addr = {m_w, m_k == 2};
      if (m_wr) begin
        e_we_n = 1'b0; e_oe = 1'b1;
        e_dq = (m_k == 2) ? m_wd[31:16] : m_wd[15:0];
      end
    end
    check("m_ready", 32'(ready), 32'(e_ready));
    check("m_addr", 32'(sram_addr), 32'(e_addr));
    check("m_we_n", 32'(sram_we_n), 32'(e_we_n));
    check("m_oe", 32'(sram_dq_oe), 32'(e_oe));
    check("m_dq_out", 32'(sram_dq_out), 32'(e_dq));
    check("m_read_data", read_data, m_rd);
    // strobes in this cycle land in memory even if reset hits at the edge
    if (m_busy && m_wr && m_k == 1) ref_mem[{m_w, 1'b0}] = m_wd[15:0];
    if (m_busy && m_wr && m_k == 2) ref_mem[{m_w, 1'b1}] = m_wd[31:16];
    if (!rst) begin
      m_busy = 1'b0; m_rd = '0;
    end else if (!m_busy) begin
      if (wr_en || rd_en) begin
        m_busy = 1'b1; m_k = 1; m_wr = wr_en;
        m_w = 17'((address - BASE) / 4); m_wd = write_data;
      end
    end else begin
      if (m_k == 2 && !m_wr) m_rd = {ref_rd({m_w, 1'b1}), ref_rd({m_w, 1'b0})};
      if (m_k == DONE_K) m_busy = 1'b0;
      else m_k++;
    end
  end

  logic        tr_ready[20];
  logic [17:0] tr_addr[20];
  logic [15:0] tr_dq[20];
  logic        tr_we[20];
  logic [31:0] tr_rd[20];
  int          tr_n;

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Drives a request and records one trace per cycle, returning at the negedge of the completing cycle.
  task automatic run_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    tr_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tr_ready[c] = ready; tr_addr[c] = sram_addr; tr_dq[c] = sram_dq_out;
      tr_we[c] = sram_we_n; tr_rd[c] = read_data;
      tr_n = c + 1;
      if (ready) break;
      next_cycle();
    end
    check("access_len", tr_n, 6);
  endtask

  function automatic logic [5:0] ready_vec();
    logic [5:0] v;
    for (int c = 0; c < 6; c++) v[c] = tr_ready[c];
    return v;
  endfunction

  task automatic idle_inputs();
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    next_cycle();
    next_cycle();
    chk_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    check("ties", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'd0);
    next_cycle();

    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    check("wr_ready_pat", 32'(ready_vec()), 32'b100000);
    check("wr_low_addr", 32'(tr_addr[1]), 32'd0);
    check("wr_low_dq", 32'(tr_dq[1]), 32'hBEEF);
    check("wr_low_we", 32'(tr_we[1]), 32'd0);
    check("wr_high_addr", 32'(tr_addr[2]), 32'd1);
    check("wr_high_dq", 32'(tr_dq[2]), 32'hDEAD);
    idle_inputs();

    bus_mem[18'd4] = 16'h5678; bus_mem[18'd5] = 16'h1234;
    ref_mem[18'd4] = 16'h5678; ref_mem[18'd5] = 16'h1234;
    run_access(1'b0, 1'b1, 32'd1032, 32'h0);
    check("rd_low_addr", 32'(tr_addr[1]), 32'd4);
    check("rd_high_addr", 32'(tr_addr[2]), 32'd5);
    check("rd_data_done", tr_rd[5], 32'h12345678);
    check("rd_we_n", 32'(tr_we[0] & tr_we[1] & tr_we[2] & tr_we[3] & tr_we[4] & tr_we[5]), 32'd1);
    idle_inputs();

    run_access(1'b1, 1'b1, 32'd1028, 32'hA5A5F00F);
    check("both_we", 32'(tr_we[1]), 32'd0);
    check("both_low_addr", 32'(tr_addr[1]), 32'd2);
    check("both_high_addr", 32'(tr_addr[2]), 32'd3);
    check("both_low_dq", 32'(tr_dq[1]), 32'hF00F);
    check("both_rd_kept", tr_rd[5], 32'h12345678);
    idle_inputs();

    run_access(1'b0, 1'b1, 32'd0, 32'h0);
    check("wrap_low_addr", 32'(tr_addr[1]), 32'h3FE00);
    check("wrap_high_addr", 32'(tr_addr[2]), 32'h3FE01);
    idle_inputs();

    wr_en = 1'b1; address = 32'd1040; write_data = 32'h13579BDF;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("abort_pre_we", 32'(sram_we_n), 32'd0);
    check("abort_pre_addr", 32'(sram_addr), 32'd9);
    next_cycle();
    rst = 1'b0; wr_en = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_rd", read_data, 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    next_cycle();

    run_access(1'b0, 1'b1, 32'd1028, 32'h0);
    check("b2b_pat0", 32'(ready_vec()), 32'b100000);
    check("b2b_rd0", tr_rd[5], 32'hA5A5F00F);
    next_cycle();
    run_access(1'b0, 1'b1, 32'd1028, 32'h0);
    check("b2b_pat1", 32'(ready_vec()), 32'b100000);
    check("b2b_rd1", tr_rd[5], 32'hA5A5F00F);
    idle_inputs();

    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst = ($urandom_range(0, 99) != 0);
      wr_en = ($urandom_range(0, 2) == 0);
      rd_en = $urandom_range(0, 1);
      address = ($urandom_range(0, 3) == 0) ? $urandom : BASE + $urandom_range(0, 63);
      write_data = $urandom;
    end
    next_cycle();
    wr_en = 1'b0; rd_en = 1'b0; rst = 1'b1;
    repeat (10) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
